vram_writer: RTL

Byte-stream command engine that drives the write side of the video block's CPU port (`sel_ram`, `sel_ctl`, `we`, `addr`, `din`). Those inputs are tied off today. This block replaces the ties. It decodes a simple opcode stream from a host byte source (UART/SPI front end, valid/ready) into registered single-cycle VRAM and control-register writes with address auto-increment. It sits in `ntsc_out_top` on the `clk` domain, between the host byte source and `video`.

---
 rtl/vram_writer_pkg.sv | 27 ++
 rtl/vram_write_port.sv | 38 +++
 rtl/vram_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vram_writer_pkg.sv
// Shared opcodes, counter widths and FSM state encoding for the VRAM command engine.
// Optional FILL command is compiled in with VRAM_WRITER_FILL_EN.
package vram_writer_pkg;

    localparam logic [7:0] OP_SETADDR = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_CTL     = 8'h03;
    localparam logic [7:0] OP_FILL    = 8'h04;

    localparam int unsigned WCNT_W = 9;
    localparam int unsigned FCNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WR_LEN,
        ST_WR_DATA,
        ST_CTL_IDX,
        ST_CTL_VAL,
        ST_FILL_HI,
        ST_FILL_LO,
        ST_FILL_VAL,
        ST_FILL_RUN
    } state_t;

endpackage

// File: rtl/vram_write_port.sv
// Registered bus-output stage: turns a write request into a one-cycle strobe
// with address/data held between writes.
module vram_write_port #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic              i_ctl,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic              o_we,
    output logic              o_sel_ram,
    output logic              o_sel_ctl,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_dout
);

    // Strobe and select for exactly one cycle per request; addr/dout update only on a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_we      <= 1'b0;
            o_sel_ram <= 1'b0;
            o_sel_ctl <= 1'b0;
            o_addr    <= '0;
            o_dout    <= '0;
        end else begin
            o_we      <= i_we;
            o_sel_ram <= i_we & ~i_ctl;
            o_sel_ctl <= i_we & i_ctl;
            if (i_we) begin
                o_addr <= i_addr;
                o_dout <= i_data;
            end
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Byte-stream command decoder driving the video block's CPU write port.
// Define VRAM_WRITER_FILL_EN to compile in the FILL (0x04) command.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CTL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sel_ram,
    output logic              sel_ctl,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              err
);

    state_t              r_state, w_next_state;
    logic [ADDR_W-1:0]   r_addr_ptr, w_addr_ptr;
    logic [7:0]          r_hi, w_hi;
    logic [CTL_W-1:0]    r_idx, w_idx;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt;
    logic                r_busy;
    logic                r_err, w_err;
    logic                w_accept;
    logic                w_req_we;
    logic                w_req_ctl;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [7:0]          w_req_data;
`ifdef VRAM_WRITER_FILL_EN
    logic [FCNT_W-1:0]   r_fcnt, w_fcnt;
    logic [7:0]          r_fval, w_fval;
    logic                r_in_ready;

    assign in_ready = r_in_ready;
`else
    assign in_ready = 1'b1;
`endif

    assign w_accept = in_valid & in_ready;
    assign busy     = r_busy;
    assign err      = r_err;

    // Next-state, datapath updates and write-request generation.
    always_comb begin
        w_next_state = r_state;
        w_addr_ptr   = r_addr_ptr;
        w_hi         = r_hi;
        w_idx        = r_idx;
        w_wcnt       = r_wcnt;
        w_err        = 1'b0;
        w_req_we     = 1'b0;
        w_req_ctl    = 1'b0;
        w_req_addr   = r_addr_ptr;
        w_req_data   = in_data;
`ifdef VRAM_WRITER_FILL_EN
        w_fcnt       = r_fcnt;
        w_fval       = r_fval;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (in_data)
                        OP_SETADDR: w_next_state = ST_ADDR_HI;
                        OP_WRITE:   w_next_state = ST_WR_LEN;
                        OP_CTL:     w_next_state = ST_CTL_IDX;
`ifdef VRAM_WRITER_FILL_EN
                        OP_FILL:    w_next_state = ST_FILL_HI;
`endif
                        default:    w_err = 1'b1;
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (w_accept) begin
                    w_hi         = in_data;
                    w_next_state = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (w_accept) begin
                    w_addr_ptr   = ADDR_W'({r_hi, in_data});
                    w_next_state = ST_IDLE;
                end
            end
            ST_WR_LEN: begin
                if (w_accept) begin
                    w_wcnt       = (in_data == 8'h00) ? WCNT_W'(256) : WCNT_W'(in_data);
                    w_next_state = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (w_accept) begin
                    w_req_we   = 1'b1;
                    w_addr_ptr = r_addr_ptr + ADDR_W'(1);
                    w_wcnt     = r_wcnt - WCNT_W'(1);
                    if (r_wcnt == WCNT_W'(1)) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_CTL_IDX: begin
                if (w_accept) begin
                    w_idx        = in_data[CTL_W-1:0];
                    w_next_state = ST_CTL_VAL;
                end
            end
            ST_CTL_VAL: begin
                if (w_accept) begin
                    w_req_we     = 1'b1;
                    w_req_ctl    = 1'b1;
                    w_req_addr   = ADDR_W'(r_idx);
                    w_next_state = ST_IDLE;
                end
            end
`ifdef VRAM_WRITER_FILL_EN
            ST_FILL_HI: begin
                if (w_accept) begin
                    w_hi         = in_data;
                    w_next_state = ST_FILL_LO;
                end
            end
            ST_FILL_LO: begin
                if (w_accept) begin
                    w_fcnt       = FCNT_W'({r_hi, in_data});
                    w_next_state = ST_FILL_VAL;
                end
            end
            ST_FILL_VAL: begin
                // First write issues on the val byte itself so it lands in the next cycle.
                if (w_accept) begin
                    w_fval = in_data;
                    if (r_fcnt == '0) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_req_we     = 1'b1;
                        w_addr_ptr   = r_addr_ptr + ADDR_W'(1);
                        w_fcnt       = r_fcnt - FCNT_W'(1);
                        w_next_state = ST_FILL_RUN;
                    end
                end
            end
            ST_FILL_RUN: begin
                // Remaining writes; one idle cycle after the last request keeps in_ready low through the last write.
                w_req_data = r_fval;
                if (r_fcnt != '0) begin
                    w_req_we   = 1'b1;
                    w_addr_ptr = r_addr_ptr + ADDR_W'(1);
                    w_fcnt     = r_fcnt - FCNT_W'(1);
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
`endif
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State and datapath registers; status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr_ptr <= '0;
            r_hi       <= '0;
            r_idx      <= '0;
            r_wcnt     <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
`ifdef VRAM_WRITER_FILL_EN
            r_fcnt     <= '0;
            r_fval     <= '0;
            r_in_ready <= 1'b1;
`endif
        end else begin
            r_state    <= w_next_state;
            r_addr_ptr <= w_addr_ptr;
            r_hi       <= w_hi;
            r_idx      <= w_idx;
            r_wcnt     <= w_wcnt;
            r_busy     <= (w_next_state != ST_IDLE);
            r_err      <= w_err;
`ifdef VRAM_WRITER_FILL_EN
            r_fcnt     <= w_fcnt;
            r_fval     <= w_fval;
            r_in_ready <= (w_next_state != ST_FILL_RUN);
`endif
        end
    end

    vram_write_port #(
        .ADDR_W (ADDR_W)
    ) u_port (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_req_we),
        .i_ctl     (w_req_ctl),
        .i_addr    (w_req_addr),
        .i_data    (w_req_data),
        .o_we      (we),
        .o_sel_ram (sel_ram),
        .o_sel_ctl (sel_ctl),
        .o_addr    (addr),
        .o_dout    (dout)
    );

endmodule
